// File: rtl/sar_pkg.sv
// sar_pkg: shared state encoding and counter-width helpers for the SAR sequencer
package sar_pkg;
  typedef enum logic [2:0] {IDLE, SAMPLE, TRIG, WAIT, DONE} state_t;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int SAMPLE_W = cnt_w(4);
  localparam int TIMEOUT_W = cnt_w(8);
  localparam int BIT_W = cnt_w(16);
endpackage

// File: rtl/sar_timer.sv
// sar_timer: loadable down-counter shared by the sample phase and the comparator timeout
module sar_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign expired = cnt == '0;
endmodule

// File: rtl/sar_sequencer.sv
// sar_sequencer: successive-approximation controller driving the capacitor DAC and comparator
module sar_sequencer #(
  parameter int Ndac     = 16,
  parameter int Nsample  = 4,
  parameter int Ntimeout = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            cfg_diffcaps,
  input  logic            comp_out,
  input  logic            comp_valid,
  output logic            sample,
  output logic            comp_trig,
  output logic [Ndac-1:0] dac_state,
  output logic            dac_diffcaps,
  output logic            busy,
  output logic            done,
  output logic [Ndac-1:0] result,
  output logic            timeout_err
);
  import sar_pkg::*;
  localparam int TW = cnt_w(Nsample > Ntimeout ? Nsample : Ntimeout);
  localparam int KW = cnt_w(Ndac);
  state_t state, state_n;
  logic [KW-1:0] k;
  logic [Ndac-1:0] dac_n;
  logic expired, accept, decide, timed_out;
  assign accept = state == IDLE && start;
  assign decide = state == WAIT && (comp_valid || expired);
  assign timed_out = state == WAIT && expired && !comp_valid;
  // the timer is reloaded at the start of each sample phase and on every comparator fire
  sar_timer #(.W(TW)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(accept || state == TRIG),
    .load_val(state == TRIG ? TW'(Ntimeout - 1) : TW'(Nsample - 1)),
    .expired(expired)
  );
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = SAMPLE;
      SAMPLE:  if (expired) state_n = TRIG;
      TRIG:    state_n = WAIT;
      WAIT:    if (decide) state_n = (k == '0) ? DONE : TRIG;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    dac_n = dac_state;
    if (accept) dac_n = '0;
    else if (state == SAMPLE && expired) dac_n[Ndac-1] = 1'b1;
    else if (decide) begin
      dac_n[k] = comp_valid & comp_out;
      if (k != '0) dac_n[k - 1'b1] = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      k            <= '0;
      dac_state    <= '0;
      dac_diffcaps <= 1'b0;
      timeout_err  <= 1'b0;
      result       <= '0;
    end else begin
      state     <= state_n;
      dac_state <= dac_n;
      if (accept) dac_diffcaps <= cfg_diffcaps;
      if (accept) timeout_err <= 1'b0;
      else if (timed_out) timeout_err <= 1'b1;
      if (state == SAMPLE) k <= KW'(Ndac - 1);
      else if (decide && k != '0) k <= k - 1'b1;
      // capture the final code on entry to DONE so result is valid alongside done
      if (decide && k == '0) result <= dac_n;
    end
  end
  assign sample = state == SAMPLE;
  assign comp_trig = state == TRIG;
  assign busy = state == SAMPLE || state == TRIG || state == WAIT;
  assign done = state == DONE;
endmodule

// File: tb/tb_sar_sequencer.sv
// tb_sar_sequencer: transaction-level SAR model predicting every output cycle, plus directed literal checks
module tb_sar_sequencer;
  localparam int ND = 4, NS = 4, NT = 8;
  logic clk = 0, rst = 1, start = 0, cfg_diffcaps = 0, comp_out = 0, comp_valid = 0;
  logic sample, comp_trig, dac_diffcaps, busy, done, timeout_err;
  logic [ND-1:0] dac_state, result;
  sar_sequencer #(.Ndac(ND), .Nsample(NS), .Ntimeout(NT)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_diffcaps(cfg_diffcaps),
    .comp_out(comp_out), .comp_valid(comp_valid), .sample(sample), .comp_trig(comp_trig),
    .dac_state(dac_state), .dac_diffcaps(dac_diffcaps), .busy(busy), .done(done),
    .result(result), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  typedef logic [2*ND+5:0] obs_t;
  obs_t q[$];
  logic [ND-1:0] h_dac = 0, h_res = 0, next_vin = 0, cur_vin = 0;
  logic h_terr = 0, h_diff = 0, idle_now = 1;
  int total = 0, bad = 0, cyc = 0, done_count = 0, done_cyc = 0, done_prev = 0, trig_count = 0;
  int next_d = 1, cur_d = 1, ccnt = 0;
  logic [4*ND-1:0] trials = 0;
  function automatic obs_t rec(input logic s, t, b, d, df, te, input logic [ND-1:0] dac, res);
    return {s, t, b, d, df, te, dac, res};
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask
  task automatic check_cycle();
    obs_t a, e;
    a = {sample, comp_trig, busy, done, dac_diffcaps, timeout_err, dac_state, result};
    idle_now = q.size() == 0;
    e = idle_now ? rec(0, 0, 0, 0, h_diff, h_terr, h_dac, h_res) : q.pop_front();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL outputs cycle %0d: got smp/trg/bsy/dn/dif/ter=%b dac=%b result=%b, want %b dac=%b result=%b",
               cyc, a[2*ND+5 -: 6], a[2*ND-1 -: ND], a[ND-1:0], e[2*ND+5 -: 6], e[2*ND-1 -: ND], e[ND-1:0]);
    end
    if (done === 1'b1) begin
      done_count++;
      done_prev = done_cyc;
      done_cyc = cyc;
    end
    if (comp_trig === 1'b1) begin
      trig_count++;
      trials = {trials[3*ND-1:0], dac_state};
    end
  endtask
  // comparator: answers cur_d cycles after each fire, junk valid during the fire cycle itself
  task automatic comparator(input logic r);
    if (r) begin
      ccnt = 0;
      comp_valid = 0;
      comp_out = 0;
    end else if (comp_trig === 1'b1) begin
      ccnt = cur_d <= NT ? cur_d : 0;
      comp_valid = 1'($urandom);
      comp_out = 1'($urandom);
    end else if (ccnt > 0) begin
      ccnt--;
      comp_valid = ccnt == 0;
      comp_out = ccnt == 0 ? (cur_vin >= dac_state) : 1'($urandom);
    end else begin
      comp_valid = 0;
      comp_out = 1'($urandom);
    end
  endtask
  task automatic model(input logic s, c, r);
    logic [ND-1:0] acc, trial;
    logic te;
    if (r) begin
      q.delete();
      h_dac = 0; h_res = 0; h_terr = 0; h_diff = 0;
      return;
    end
    if (!(idle_now && s)) return;
    cur_vin = next_vin;
    cur_d = next_d;
    acc = 0;
    te = 0;
    repeat (NS) q.push_back(rec(1, 0, 1, 0, c, 0, '0, h_res));
    for (int b = ND - 1; b >= 0; b--) begin
      trial = acc | (ND'(1) << b);
      q.push_back(rec(0, 1, 1, 0, c, te, trial, h_res));
      repeat (cur_d <= NT ? cur_d : NT) q.push_back(rec(0, 0, 1, 0, c, te, trial, h_res));
      if (cur_d > NT) te = 1;
      else if (cur_vin >= trial) acc = trial;
    end
    q.push_back(rec(0, 0, 0, 1, c, te, acc, acc));
    h_dac = acc; h_res = acc; h_terr = te; h_diff = c;
  endtask
  task automatic tick(input logic s, c, r);
    @(negedge clk);
    cyc++;
    check_cycle();
    start = s;
    cfg_diffcaps = c;
    rst = r;
    comparator(r);
    model(s, c, r);
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) tick(0, 0, 0);
  endtask
  task automatic run_conv(input logic [ND-1:0] v, input int d, input logic c,
                          output int lat, output logic [ND-1:0] res, output logic te, output logic te0);
    int t0, dc;
    next_vin = v;
    next_d = d;
    tick(1, c, 0);
    t0 = cyc;
    dc = done_count;
    lat = -1;
    te0 = 1;
    for (int i = 0; i < 100 && done_count == dc; i++) begin
      tick(0, c, 0);
      if (i == 0) te0 = timeout_err;
    end
    if (done_count != dc) lat = done_cyc - t0;
    res = result;
    te = timeout_err;
  endtask
  initial begin
    int lat, t0, dc;
    logic [ND-1:0] res;
    logic te, te0;
    repeat (3) @(posedge clk);
    tick(0, 0, 0);
    chk("reset outputs", int'({sample, comp_trig, busy, done, dac_diffcaps, timeout_err, dac_state, result}), 0);
    t0 = trig_count;
    run_conv(4'b1010, 1, 0, lat, res, te, te0);
    chk("fast latency", lat, 13);
    chk("fast result", int'(res), 10);
    chk("fast timeout_err", int'(te), 0);
    chk("fast trials", int'(trials), 16'h8CAB);
    chk("fast trig count", trig_count - t0, 4);
    t0 = trig_count;
    run_conv(4'b1111, 3, 0, lat, res, te, te0);
    chk("slow latency", lat, 21);
    chk("slow result", int'(res), 15);
    chk("slow trig count", trig_count - t0, 4);
    run_conv(4'b1100, NT + 1, 0, lat, res, te, te0);
    chk("timeout latency", lat, 41);
    chk("timeout result", int'(res), 0);
    chk("timeout flag", int'(te), 1);
    run_conv(4'b0101, NT, 0, lat, res, te, te0);
    chk("timeout cleared on start", int'(te0), 0);
    chk("edge valid latency", lat, 41);
    chk("edge valid result", int'(res), 5);
    chk("edge valid no timeout", int'(te), 0);
    next_vin = 4'b1001;
    next_d = 1;
    dc = done_count;
    repeat (45) tick(1, 0, 0);
    chk("held start done count", done_count - dc, 3);
    chk("held start done spacing", done_cyc - done_prev, 14);
    drain();
    next_vin = 4'b0011;
    next_d = 2;
    tick(1, 1, 0);
    repeat (6) tick(0, 0, 0);
    chk("diffcaps held", int'(dac_diffcaps), 1);
    drain();
    tick(1, 0, 0);
    tick(0, 0, 0);
    chk("diffcaps relatched", int'(dac_diffcaps), 0);
    drain();
    next_vin = 4'b1010;
    next_d = 3;
    tick(1, 0, 0);
    repeat (10) tick(0, 0, 0);
    chk("bit2 wait dac", int'(dac_state), 12);
    chk("bit2 wait busy", int'({busy, comp_trig}), 2);
    tick(0, 0, 1);
    tick(0, 0, 0);
    chk("outputs after rst", int'({sample, comp_trig, busy, done, dac_diffcaps, timeout_err, dac_state, result}), 0);
    dc = done_count;
    repeat (25) tick(0, 0, 0);
    chk("no done after rst", done_count - dc, 0);
    run_conv(4'b1010, 1, 0, lat, res, te, te0);
    chk("post-rst result", int'(res), 10);
    chk("post-rst latency", lat, 13);
    for (int i = 0; i < 3000; i++) begin
      next_vin = ND'($urandom);
      next_d = $urandom_range(NT + 1, 1);
      tick($urandom % 3 == 0, 1'($urandom), $urandom % 250 == 0);
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
